// File: rtl/irq_ctrl16.sv
// rtl/irq_ctrl16.sv - edge-triggered priority interrupt controller with ack/EOI in-service tracking
// Optional preemptive nesting is enabled by defining IRQ_NEST_EN.
module irq_ctrl16 #(
    parameter int CIrqCnt = 16,
    parameter int CIdxW   = 4
) (
    input  logic               AClkH,
    input  logic               AResetH,
    input  logic               AClkHEn,
    input  logic [CIrqCnt-1:0] AIrqI,
    input  logic               AIrqAck,
    input  logic               AIrqEoi,
    output logic               AIrqReq,
    output logic [CIdxW-1:0]   AIrqIdx,
    output logic [CIrqCnt-1:0] APend,
    output logic [CIrqCnt-1:0] AInServ
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e             state_q;
    logic               req_q;
    logic [CIdxW-1:0]   idx_q;
    logic [CIrqCnt-1:0] irq_prev_q;
    logic [CIrqCnt-1:0] pend_q;
    logic [CIrqCnt-1:0] pend_d;
    logic [CIrqCnt-1:0] in_serv_q;
    logic [CIrqCnt-1:0] in_serv_d;

    logic [CIrqCnt-1:0] edge_det;
    logic [CIrqCnt-1:0] ack_set;
    logic [CIrqCnt-1:0] eoi_clr;
    logic               ack_fire;
    logic               cand_vld;
    logic [CIdxW-1:0]   cand_idx;
    logic               cand_ok;

    // Ack clears pending and sets in-service for the presented source; a fresh edge on
    // the same line re-arms pending, and EOI retires the lowest (innermost) in-service bit.
    always_comb begin
        edge_det  = AIrqI & ~irq_prev_q;
        ack_fire  = (state_q == ST_REQ) && AIrqAck;
        ack_set   = ack_fire ? (CIrqCnt'(1) << idx_q) : '0;
        eoi_clr   = AIrqEoi ? (in_serv_q & (~in_serv_q + CIrqCnt'(1))) : '0;
        pend_d    = (pend_q & ~ack_set) | edge_det;
        in_serv_d = (in_serv_q & ~eoi_clr) | ack_set;
    end

    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        for (int i = CIrqCnt - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                cand_vld = 1'b1;
                cand_idx = CIdxW'(i);
            end
        end
    end

`ifdef IRQ_NEST_EN
    logic             serv_vld;
    logic [CIdxW-1:0] serv_idx;

    // Only a strictly higher-priority source than the innermost in-service one may preempt.
    always_comb begin
        serv_vld = 1'b0;
        serv_idx = '0;
        for (int i = CIrqCnt - 1; i >= 0; i--) begin
            if (in_serv_q[i]) begin
                serv_vld = 1'b1;
                serv_idx = CIdxW'(i);
            end
        end
        cand_ok = cand_vld && (!serv_vld || (cand_idx < serv_idx));
    end
`else
    always_comb begin
        cand_ok = cand_vld && (in_serv_q == '0);
    end
`endif

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            idx_q      <= '0;
            irq_prev_q <= '0;
            pend_q     <= '0;
            in_serv_q  <= '0;
        end else if (AClkHEn) begin
            irq_prev_q <= AIrqI;
            pend_q     <= pend_d;
            in_serv_q  <= in_serv_d;
            case (state_q)
                ST_IDLE: begin
                    if (cand_ok) begin
                        idx_q   <= cand_idx;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Index stays frozen here until the core acknowledges.
                    if (AIrqAck) begin
                        req_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign AIrqReq = req_q;
    assign AIrqIdx = idx_q;
    assign APend   = pend_q;
    assign AInServ = in_serv_q;

endmodule

// File: tb/tb_irq_ctrl16.sv
// tb/tb_irq_ctrl16.sv - scoreboard bench for irq_ctrl16 against a bit-array reference model
module tb_irq_ctrl16;

    localparam int NIRQ = 16;
`ifdef IRQ_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        ack = 1'b0;
    logic        eoi = 1'b0;
    logic [15:0] irq = '0;
    logic        req;
    logic [3:0]  idx;
    logic [15:0] pend;
    logic [15:0] inserv;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_ctrl16 #(.CIrqCnt(NIRQ), .CIdxW(4)) dut (
        .AClkH   (clk),
        .AResetH (rst),
        .AClkHEn (en),
        .AIrqI   (irq),
        .AIrqAck (ack),
        .AIrqEoi (eoi),
        .AIrqReq (req),
        .AIrqIdx (idx),
        .APend   (pend),
        .AInServ (inserv)
    );

    typedef struct {
        logic        req;
        logic [3:0]  idx;
        logic [15:0] pend;
        logic [15:0] serv;
    } exp_t;

    exp_t exp_q[$];

    bit m_prev[NIRQ];
    bit m_pend[NIRQ];
    bit m_serv[NIRQ];
    bit m_req;
    int m_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: per enabled cycle, edges arm pending, ack moves the presented source
    // into service, EOI retires the highest-priority in-service source.
    task automatic model_step(input bit r, input bit e, input logic [15:0] lines,
                              input bit a, input bit o);
        exp_t s;
        bit   ack_ok;
        int   cand;
        int   top;
        if (r) begin
            for (int i = 0; i < NIRQ; i++) begin
                m_prev[i] = 0;
                m_pend[i] = 0;
                m_serv[i] = 0;
            end
            m_req = 0;
            m_idx = 0;
        end else if (e) begin
            ack_ok = m_req && a;
            cand = -1;
            top = -1;
            for (int i = 0; i < NIRQ; i++) begin
                if (m_pend[i] && cand < 0) cand = i;
                if (m_serv[i] && top < 0) top = i;
            end
            for (int i = 0; i < NIRQ; i++) begin
                m_pend[i] = (m_pend[i] && !(ack_ok && i == m_idx)) || (lines[i] && !m_prev[i]);
                m_prev[i] = lines[i];
            end
            if (o && top >= 0) m_serv[top] = 0;
            if (ack_ok) m_serv[m_idx] = 1;
            if (m_req) begin
                if (ack_ok) m_req = 0;
            end else if (cand >= 0 && (top < 0 || (NEST && cand < top))) begin
                m_req = 1;
                m_idx = cand;
            end
        end
        s.req = m_req;
        s.idx = 4'(m_idx);
        for (int i = 0; i < NIRQ; i++) begin
            s.pend[i] = m_pend[i];
            s.serv[i] = m_serv[i];
        end
        exp_q.push_back(s);
    endtask

    task automatic tick(input logic [15:0] l, input bit a, input bit o, input bit r, input bit e);
        @(posedge clk);
        #2;
        rst = r;
        en  = e;
        irq = l;
        ack = a;
        eoi = o;
        model_step(r, e, l, a, o);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_req", 32'(req), 32'(e.req));
                if (e.req) chk("sb_idx", 32'(idx), 32'(e.idx));
                chk("sb_pend", 32'(pend), 32'(e.pend));
                chk("sb_inserv", 32'(inserv), 32'(e.serv));
            end
        end
    end

    initial begin : stim
        logic [15:0] rl;
        tick(16'h0, 0, 0, 1, 1);
        tick(16'h0, 0, 0, 1, 1);
        tick(16'h0, 0, 0, 0, 1);
        chk("reset_req", 32'(req), 32'd0);
        chk("reset_idx", 32'(idx), 32'd0);
        chk("reset_pend", 32'(pend), 32'd0);
        chk("reset_inserv", 32'(inserv), 32'd0);

        // single source on bit 5
        tick(16'h0020, 0, 0, 0, 1);
        tick(16'h0020, 0, 0, 0, 1);
        chk("single_pend", 32'(pend), 32'h0020);
        chk("single_req_early", 32'(req), 32'd0);
        tick(16'h0020, 0, 0, 0, 1);
        chk("single_req", 32'(req), 32'd1);
        chk("single_idx", 32'(idx), 32'd5);
        tick(16'h0020, 1, 0, 0, 1);
        tick(16'h0020, 0, 0, 0, 1);
        chk("single_ack_pend", 32'(pend), 32'd0);
        chk("single_ack_inserv", 32'(inserv), 32'h0020);
        chk("single_ack_req", 32'(req), 32'd0);
        tick(16'h0020, 0, 1, 0, 1);
        tick(16'h0020, 0, 0, 0, 1);
        chk("single_eoi_inserv", 32'(inserv), 32'd0);

        // priority: bits 9 and 3 together
        tick(16'h0000, 0, 0, 0, 1);
        tick(16'h0208, 0, 0, 0, 1);
        tick(16'h0208, 0, 0, 0, 1);
        tick(16'h0208, 0, 0, 0, 1);
        chk("prio_first_idx", 32'(idx), 32'd3);
        tick(16'h0208, 1, 0, 0, 1);
        tick(16'h0208, 0, 1, 0, 1);
        chk("prio_blocked_req", 32'(req), 32'd0);
        tick(16'h0208, 0, 0, 0, 1);
        tick(16'h0208, 0, 0, 0, 1);
        chk("prio_second_req", 32'(req), 32'd1);
        chk("prio_second_idx", 32'(idx), 32'd9);

        // frozen index while bit 1 arrives
        tick(16'h020a, 0, 0, 0, 1);
        tick(16'h020a, 0, 0, 0, 1);
        tick(16'h020a, 0, 0, 0, 1);
        chk("frozen_idx", 32'(idx), 32'd9);
        tick(16'h020a, 1, 0, 0, 1);
        tick(16'h020a, 0, 0, 0, 1);
        tick(16'h020a, 0, 0, 0, 1);
        chk("frozen_next_req", 32'(req), 32'(NEST));
        chk("frozen_inserv9", 32'(inserv[9]), 32'd1);

        // edge on bit 4 coincident with its ack
        tick(16'h0000, 0, 0, 1, 1);
        tick(16'h0000, 0, 0, 0, 1);
        tick(16'h0010, 0, 0, 0, 1);
        tick(16'h0010, 0, 0, 0, 1);
        tick(16'h0000, 0, 0, 0, 1);
        chk("coinc_idx", 32'(idx), 32'd4);
        tick(16'h0010, 1, 0, 0, 1);
        tick(16'h0010, 0, 0, 0, 1);
        chk("coinc_pend", 32'(pend), 32'h0010);
        chk("coinc_inserv", 32'(inserv), 32'h0010);

        // reset during request, line held through release
        tick(16'h0010, 0, 1, 0, 1);
        tick(16'h0010, 0, 0, 0, 1);
        tick(16'h0010, 0, 0, 0, 1);
        chk("rreq_req", 32'(req), 32'd1);
        tick(16'h0010, 0, 0, 1, 1);
        tick(16'h0010, 0, 0, 0, 1);
        chk("rreq_cleared", 32'({req, pend, inserv}), 32'd0);
        tick(16'h0010, 0, 0, 0, 1);
        chk("held_edge_pend", 32'(pend), 32'h0010);

        // ack ignored while disabled
        tick(16'h0010, 0, 0, 0, 1);
        tick(16'h0010, 1, 0, 0, 0);
        tick(16'h0010, 0, 0, 0, 1);
        chk("en_low_req", 32'(req), 32'd1);
        chk("en_low_inserv", 32'(inserv), 32'd0);

        // randomized traffic
        rl = 16'h0;
        for (int n = 0; n < 3000; n++) begin
            rl = rl ^ 16'($urandom & $urandom & $urandom & $urandom);
            tick(rl, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0);
        end

        tick(16'h0, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        #3;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
